// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: DEPTH-entry circular FIFO with valid/ready handshake,
// synchronous flush and asynchronous active-high reset. DEPTH=1 acts as a plain stage register.
// Optional feature: define PIPE_BUBBLE_CNT_EN to add bubble_cnt_o, a saturating 16-bit count of
// cycles where the downstream stage was ready but the buffer was empty.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  count_o
`ifdef PIPE_BUBBLE_CNT_EN
  ,
  output logic [15:0]       bubble_cnt_o
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  // Handshake outputs come from registered occupancy only; no path from out_ready_i.
  always_comb begin
    in_ready_o  = (count_q < FullCnt);
    out_valid_o = (count_q != '0);
    out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
    count_o     = count_q;
    push        = in_valid_i & in_ready_o;
    pop         = out_valid_o & out_ready_i;
  end

  // Next-state: flush wins over everything; pointers wrap by explicit compare.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

`ifdef PIPE_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q;

  // Saturating bubble counter; flush does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (out_ready_i && !out_valid_o && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
